// File: rtl/ina226_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ina226_pkg
// Description : Shared definitions for the INA226-style I2C target: one-hot
//               state encoding, bus acknowledge levels and data widths.
// Revision    : 1.0 - initial release
// ============================================================================
package ina226_pkg;

  localparam int BYTE_W = 8;
  localparam int REG_W  = 16;

  // Level on SDA during an acknowledge bit
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam int ST_W = 14;
  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_IDLE     = 14'b00_0000_0000_0001;
  localparam state_t ST_RX_ADDR  = 14'b00_0000_0000_0010;
  localparam state_t ST_ACK_ADDR = 14'b00_0000_0000_0100;
  localparam state_t ST_RX_PTR   = 14'b00_0000_0000_1000;
  localparam state_t ST_ACK_PTR  = 14'b00_0000_0001_0000;
  localparam state_t ST_RX_MSB   = 14'b00_0000_0010_0000;
  localparam state_t ST_ACK_MSB  = 14'b00_0000_0100_0000;
  localparam state_t ST_RX_LSB   = 14'b00_0000_1000_0000;
  localparam state_t ST_ACK_LSB  = 14'b00_0001_0000_0000;
  localparam state_t ST_TX_MSB   = 14'b00_0010_0000_0000;
  localparam state_t ST_MACK_MSB = 14'b00_0100_0000_0000;
  localparam state_t ST_TX_LSB   = 14'b00_1000_0000_0000;
  localparam state_t ST_MACK_LSB = 14'b01_0000_0000_0000;
  localparam state_t ST_IGNORE   = 14'b10_0000_0000_0000;

endpackage
`default_nettype wire

// File: rtl/ina226_i2c_target_line_filter.sv
`default_nettype none
// ============================================================================
// Module      : i2c_line_filter
// Description : Two-flop synchronizer followed by a stability filter. A new
//               level is accepted only after it has been seen for FILT_LEN
//               consecutive clocks. Emits one-cycle rise/fall pulses that
//               coincide with the cycle the filtered level changes.
// Ports       : clk_i   - fabric clock
//               rst_i   - asynchronous active-high reset (line presets to 1)
//               line_i  - raw pad input
//               level_o - filtered level
//               rise_o  - one-cycle pulse, filtered level went 0->1
//               fall_o  - one-cycle pulse, filtered level went 1->0
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_line_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

  logic [1:0]       sync_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], line_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // The counter runs only while the synchronized input disagrees with the
  // accepted level; any bounce back to the old level restarts it.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
        rise_d  = sync_q[1];
        fall_d  = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule
`default_nettype wire

// File: rtl/ina226_i2c_target.sv
`default_nettype none
// ============================================================================
// Module      : ina226_i2c_target
// Description : I2C target speaking the INA226 register protocol: address
//               byte, pointer byte, then 16-bit register data MSB first.
//               Register storage lives outside, behind a strobe interface.
// Ports       : clk_i         - fabric clock
//               rst_i         - asynchronous active-high reset
//               address_i     - 7-bit I2C address answered to
//               scl_i, sda_i  - raw pad inputs
//               sda_en_o      - 1 = pull SDA low (open drain)
//               pointer_o     - current register pointer
//               wr_strobe_o   - one-cycle pulse, wr_data_o valid for pointer_o
//               wr_data_o     - last received register value
//               rd_strobe_o   - one-cycle pulse when rd_data_i is captured
//               rd_data_i     - register map contents for pointer_o
//               busy_o        - state is not Idle
//               timeout_err_o - sticky SCL-stall flag, cleared by START
// Revision    : 1.0 - initial release
// ============================================================================
module ina226_i2c_target
  import ina226_pkg::*;
#(
  parameter int FILT_LEN = 4,
  parameter int TIMEOUT  = 65535
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [6:0]        address_i,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_en_o,
  output logic [BYTE_W-1:0] pointer_o,
  output logic              wr_strobe_o,
  output logic [REG_W-1:0]  wr_data_o,
  output logic              rd_strobe_o,
  input  logic [REG_W-1:0]  rd_data_i,
  output logic              busy_o,
  output logic              timeout_err_o
);

  localparam int             TO_W     = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);
  localparam logic [3:0]     BIT_LAST = 4'd7;
  localparam logic [3:0]     BIT_DONE = 4'd8;

  // ---------------------------------------------------------------- inputs
  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk_i(clk_i), .rst_i(rst_i), .line_i(scl_i),
    .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk_i(clk_i), .rst_i(rst_i), .line_i(sda_i),
    .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  logic w_start, w_stop;
  assign w_start = sda_fall & scl_lvl;
  assign w_stop  = sda_rise & scl_lvl;

  // ------------------------------------------------------------- registers
  state_t              state_q, state_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]   rx_q, rx_d;
  logic [BYTE_W-1:0]   msb_q, msb_d;
  logic [REG_W-1:0]    tx_q, tx_d;
  logic                rw_q, rw_d;
  logic                mack_q, mack_d;
  logic                sda_en_q, sda_en_d;
  logic [BYTE_W-1:0]   pointer_q, pointer_d;
  logic [REG_W-1:0]    wr_data_q, wr_data_d;
  logic                wr_strobe_q, wr_strobe_d;
  logic                rd_strobe_q, rd_strobe_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic                timeout_err_q, timeout_err_d;

  logic [BYTE_W-1:0]   w_byte;
  logic                w_to_hit;

  assign w_byte   = {rx_q[BYTE_W-2:0], sda_lvl};
  assign w_to_hit = (state_q != ST_IDLE) && (to_cnt_q == TO_LIMIT);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt_q     <= '0;
      rx_q          <= '0;
      msb_q         <= '0;
      tx_q          <= '0;
      rw_q          <= 1'b0;
      mack_q        <= NACK;
      sda_en_q      <= 1'b0;
      pointer_q     <= '0;
      wr_data_q     <= '0;
      wr_strobe_q   <= 1'b0;
      rd_strobe_q   <= 1'b0;
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      bit_cnt_q     <= bit_cnt_d;
      rx_q          <= rx_d;
      msb_q         <= msb_d;
      tx_q          <= tx_d;
      rw_q          <= rw_d;
      mack_q        <= mack_d;
      sda_en_q      <= sda_en_d;
      pointer_q     <= pointer_d;
      wr_data_q     <= wr_data_d;
      wr_strobe_q   <= wr_strobe_d;
      rd_strobe_q   <= rd_strobe_d;
      to_cnt_q      <= to_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state and datapath logic. SDA enable only ever changes on a
  // filtered SCL fall, START/STOP or timeout, never during SCL high.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_d          = rx_q;
    msb_d         = msb_q;
    tx_d          = tx_q;
    rw_d          = rw_q;
    mack_d        = mack_q;
    sda_en_d      = sda_en_q;
    pointer_d     = pointer_q;
    wr_data_d     = wr_data_q;
    wr_strobe_d   = 1'b0;
    rd_strobe_d   = 1'b0;
    timeout_err_d = timeout_err_q;

    if ((state_q == ST_IDLE) || scl_rise || scl_fall || w_to_hit) to_cnt_d = '0;
    else                                                          to_cnt_d = to_cnt_q + 1'b1;

    if (w_start) begin
      state_d       = ST_RX_ADDR;
      bit_cnt_d     = '0;
      sda_en_d      = 1'b0;
      timeout_err_d = 1'b0;
    end else if (w_stop) begin
      state_d  = ST_IDLE;
      sda_en_d = 1'b0;
    end else if (w_to_hit) begin
      state_d       = ST_IDLE;
      sda_en_d      = 1'b0;
      timeout_err_d = 1'b1;
    end else begin
      case (state_q)
        ST_RX_ADDR, ST_RX_PTR, ST_RX_MSB, ST_RX_LSB: begin
          if (scl_rise && (bit_cnt_q < BIT_DONE)) begin
            rx_d      = w_byte;
            bit_cnt_d = bit_cnt_q + 1'b1;
            // Completed bytes commit on the 8th rise, before the ACK bit,
            // so a STOP mid-byte leaves pointer and write data untouched.
            if (bit_cnt_q == BIT_LAST) begin
              if (state_q == ST_RX_PTR) pointer_d = w_byte;
              if (state_q == ST_RX_MSB) msb_d     = w_byte;
              if (state_q == ST_RX_LSB) begin
                wr_data_d   = {msb_q, w_byte};
                wr_strobe_d = 1'b1;
              end
            end
          end else if (scl_fall && (bit_cnt_q == BIT_DONE)) begin
            bit_cnt_d = '0;
            sda_en_d  = 1'b1;
            case (state_q)
              ST_RX_ADDR: begin
                if (rx_q[BYTE_W-1:1] == address_i) begin
                  rw_d    = rx_q[0];
                  state_d = ST_ACK_ADDR;
                end else begin
                  sda_en_d = 1'b0;
                  state_d  = ST_IGNORE;
                end
              end
              ST_RX_PTR: state_d = ST_ACK_PTR;
              ST_RX_MSB: state_d = ST_ACK_MSB;
              default:   state_d = ST_ACK_LSB;
            endcase
          end
        end

        ST_ACK_ADDR: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            if (rw_q) begin
              tx_d        = rd_data_i;
              rd_strobe_d = 1'b1;
              sda_en_d    = ~rd_data_i[REG_W-1];
              state_d     = ST_TX_MSB;
            end else begin
              sda_en_d = 1'b0;
              state_d  = ST_RX_PTR;
            end
          end
        end

        ST_ACK_PTR, ST_ACK_MSB, ST_ACK_LSB: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            sda_en_d  = 1'b0;
            if      (state_q == ST_ACK_PTR) state_d = ST_RX_MSB;
            else if (state_q == ST_ACK_MSB) state_d = ST_RX_LSB;
            else                            state_d = ST_IGNORE;
          end
        end

        ST_TX_MSB, ST_TX_LSB: begin
          if (scl_rise && (bit_cnt_q < BIT_DONE)) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else if (scl_fall) begin
            // tx_q[15] is always the bit currently on the bus
            tx_d = tx_q << 1;
            if (bit_cnt_q == BIT_DONE) begin
              bit_cnt_d = '0;
              sda_en_d  = 1'b0;
              state_d   = (state_q == ST_TX_MSB) ? ST_MACK_MSB : ST_MACK_LSB;
            end else begin
              sda_en_d = ~tx_q[REG_W-2];
            end
          end
        end

        ST_MACK_MSB: begin
          if (scl_rise && (bit_cnt_q == 4'd0)) begin
            mack_d    = sda_lvl;
            bit_cnt_d = 4'd1;
          end else if (scl_fall && (bit_cnt_q == 4'd1)) begin
            bit_cnt_d = '0;
            if (mack_q == ACK) begin
              sda_en_d = ~tx_q[REG_W-1];
              state_d  = ST_TX_LSB;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end

        ST_MACK_LSB: begin
          if (scl_rise) state_d = ST_IGNORE;
        end

        ST_IGNORE: sda_en_d = 1'b0;

        ST_IDLE: ;

        default: begin
          state_d  = ST_IDLE;
          sda_en_d = 1'b0;
        end
      endcase
    end
  end

  // Outputs
  always_comb begin
    busy_o        = (state_q != ST_IDLE);
    sda_en_o      = sda_en_q;
    pointer_o     = pointer_q;
    wr_strobe_o   = wr_strobe_q;
    wr_data_o     = wr_data_q;
    rd_strobe_o   = rd_strobe_q;
    timeout_err_o = timeout_err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_ina226_i2c_target.sv
`default_nettype none
// ============================================================================
// Module      : tb_ina226_i2c_target
// Description : Bit-level I2C master driving ina226_i2c_target, with
//               scoreboard queues for ACK bits, write strobes, read strobes
//               and read-back bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ina226_i2c_target;

  localparam int FILT = 4;
  localparam int TMO  = 400;
  localparam int Q    = 10;   // quarter SCL period in clocks

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  address = 7'h40;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_bus;
  logic        sda_en;
  logic [7:0]  pointer;
  logic        wr_strobe;
  logic [15:0] wr_data;
  logic        rd_strobe;
  logic [15:0] rd_data;
  logic        busy;
  logic        timeout_err;

  always #5 clk = ~clk;

  assign sda_bus = sda_m & ~sda_en;

  function automatic logic [15:0] regmap(input logic [7:0] p);
    case (p)
      8'h02:   return 16'h1F40;
      8'h05:   return 16'hBEEF;
      default: return {8'hA5, p};
    endcase
  endfunction

  assign rd_data = regmap(pointer);

  ina226_i2c_target #(.FILT_LEN(FILT), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .address_i(address),
    .scl_i(scl_m), .sda_i(sda_bus), .sda_en_o(sda_en),
    .pointer_o(pointer), .wr_strobe_o(wr_strobe), .wr_data_o(wr_data),
    .rd_strobe_o(rd_strobe), .rd_data_i(rd_data), .busy_o(busy),
    .timeout_err_o(timeout_err)
  );

  // Scoreboard
  logic        ack_q[$];
  logic [15:0] wr_q[$];
  logic [7:0]  rdptr_q[$];
  logic [7:0]  rdbyte_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          sda_en_cycles = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Per-cycle observation of DUT strobes, sampled on the falling clock edge
  task automatic monitor();
    if (sda_en) sda_en_cycles++;
    if (wr_strobe) begin
      if (wr_q.size() > 0) check_eq("wr_data", {16'h0, wr_data}, {16'h0, wr_q.pop_front()});
      else                 check_eq("wr_unexpected", 32'(wr_q.size()), 32'd1);
    end
    if (rd_strobe) begin
      if (rdptr_q.size() > 0) check_eq("rd_pointer", {24'h0, pointer}, {24'h0, rdptr_q.pop_front()});
      else                    check_eq("rd_unexpected", 32'(rdptr_q.size()), 32'd1);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      monitor();
    end
  endtask

  task automatic xfer_bit(input logic b, output logic s);
    tick(Q); sda_m = b;
    tick(Q); scl_m = 1'b1;
    tick(Q); s = sda_bus;
    tick(Q); scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    tick(2*Q); sda_m = 1'b0;
    tick(2*Q); scl_m = 1'b0;
  endtask

  task automatic i2c_rstart();
    tick(Q);   sda_m = 1'b1;
    tick(Q);   scl_m = 1'b1;
    tick(2*Q); sda_m = 1'b0;
    tick(2*Q); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(Q);   sda_m = 1'b0;
    tick(Q);   scl_m = 1'b1;
    tick(2*Q); sda_m = 1'b1;
    tick(2*Q);
  endtask

  task automatic write_byte(input logic [7:0] d, input logic exp_ack);
    logic s;
    ack_q.push_back(exp_ack);
    for (int i = 7; i >= 0; i--) xfer_bit(d[i], s);
    xfer_bit(1'b1, s);
    check_eq($sformatf("ack_%02h", d), {31'h0, s}, {31'h0, ack_q.pop_front()});
  endtask

  task automatic read_byte(input logic [7:0] exp, input logic mack);
    logic       s;
    logic [7:0] v;
    v = '0;
    rdbyte_q.push_back(exp);
    for (int i = 0; i < 8; i++) begin
      xfer_bit(1'b1, s);
      v = {v[6:0], s};
    end
    check_eq("rd_byte", {24'h0, v}, {24'h0, rdbyte_q.pop_front()});
    xfer_bit(mack, s);
  endtask

  initial begin
    logic s;
    int   en0;
    #2 rst = 1'b1;
    tick(5);
    check_eq("rst_sda_en",  {31'h0, sda_en}, 32'h0);
    check_eq("rst_pointer", {24'h0, pointer}, 32'h0);
    check_eq("rst_wr_data", {16'h0, wr_data}, 32'h0);
    check_eq("rst_wr_strb", {31'h0, wr_strobe}, 32'h0);
    check_eq("rst_rd_strb", {31'h0, rd_strobe}, 32'h0);
    check_eq("rst_busy",    {31'h0, busy}, 32'h0);
    check_eq("rst_tmo_err", {31'h0, timeout_err}, 32'h0);
    rst = 1'b0;
    tick(10);

    // Full register write
    wr_q.push_back(16'h4527);
    i2c_start();
    write_byte(8'h80, 1'b0); write_byte(8'h00, 1'b0);
    write_byte(8'h45, 1'b0); write_byte(8'h27, 1'b0);
    i2c_stop();
    check_eq("wr_pointer", {24'h0, pointer}, 32'h00);
    check_eq("wr_hold",    {16'h0, wr_data}, 32'h4527);
    check_eq("wr_busy",    {31'h0, busy}, 32'h0);

    // Pointer-only write, then read
    i2c_start();
    write_byte(8'h80, 1'b0); write_byte(8'h02, 1'b0);
    i2c_stop();
    check_eq("ptr_only", {24'h0, pointer}, 32'h02);
    rdptr_q.push_back(8'h02);
    i2c_start();
    write_byte(8'h81, 1'b0);
    read_byte(8'h1F, 1'b0);
    read_byte(8'h40, 1'b1);
    i2c_stop();
    check_eq("rd_busy", {31'h0, busy}, 32'h0);

    // Foreign address: never ACKed, SDA never driven
    en0 = sda_en_cycles;
    i2c_start();
    write_byte(8'h82, 1'b1); write_byte(8'h00, 1'b1);
    check_eq("ign_busy", {31'h0, busy}, 32'h1);
    i2c_stop();
    check_eq("ign_idle", {31'h0, busy}, 32'h0);
    check_eq("ign_sda_en", 32'(sda_en_cycles - en0), 32'h0);

    // Repeated START read
    i2c_start();
    write_byte(8'h80, 1'b0); write_byte(8'h05, 1'b0);
    rdptr_q.push_back(8'h05);
    i2c_rstart();
    write_byte(8'h81, 1'b0);
    read_byte(8'hBE, 1'b0);
    read_byte(8'hEF, 1'b1);
    i2c_stop();
    check_eq("rs_pointer", {24'h0, pointer}, 32'h05);

    // STOP after 4 bits of MSB
    i2c_start();
    write_byte(8'h80, 1'b0); write_byte(8'h03, 1'b0);
    xfer_bit(1'b1, s); xfer_bit(1'b0, s); xfer_bit(1'b1, s); xfer_bit(1'b0, s);
    i2c_stop();
    check_eq("part_pointer", {24'h0, pointer}, 32'h03);
    check_eq("part_wr_data", {16'h0, wr_data}, 32'h4527);
    check_eq("part_busy",    {31'h0, busy}, 32'h0);

    // SCL frozen low in RxLsb
    i2c_start();
    write_byte(8'h80, 1'b0); write_byte(8'h00, 1'b0); write_byte(8'h12, 1'b0);
    xfer_bit(1'b1, s); xfer_bit(1'b1, s); xfer_bit(1'b0, s);
    tick(TMO - 20);
    check_eq("tmo_pre_busy", {31'h0, busy}, 32'h1);
    check_eq("tmo_pre_err",  {31'h0, timeout_err}, 32'h0);
    tick(60);
    check_eq("tmo_err",    {31'h0, timeout_err}, 32'h1);
    check_eq("tmo_busy",   {31'h0, busy}, 32'h0);
    check_eq("tmo_sda_en", {31'h0, sda_en}, 32'h0);
    i2c_stop();
    check_eq("tmo_sticky", {31'h0, timeout_err}, 32'h1);

    // Reset while the target drives the MSB acknowledge
    i2c_start();
    check_eq("start_clr_err", {31'h0, timeout_err}, 32'h0);
    write_byte(8'h80, 1'b0); write_byte(8'h07, 1'b0);
    for (int i = 7; i >= 0; i--) xfer_bit(((8'h12 >> i) & 8'h1) != 8'h0, s);
    tick(Q); sda_m = 1'b1;
    tick(Q); scl_m = 1'b1;
    tick(Q);
    check_eq("ackmsb_drive", {31'h0, sda_en}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_sda_en",  {31'h0, sda_en}, 32'h0);
    check_eq("mid_rst_pointer", {24'h0, pointer}, 32'h0);
    check_eq("mid_rst_wr_data", {16'h0, wr_data}, 32'h0);
    check_eq("mid_rst_busy",    {31'h0, busy}, 32'h0);
    tick(10);
    rst = 1'b0;
    tick(10);
    wr_q.push_back(16'h1234);
    i2c_start();
    write_byte(8'h80, 1'b0); write_byte(8'h07, 1'b0);
    write_byte(8'h12, 1'b0); write_byte(8'h34, 1'b0);
    i2c_stop();
    check_eq("post_rst_pointer", {24'h0, pointer}, 32'h07);
    check_eq("post_rst_wr_data", {16'h0, wr_data}, 32'h1234);

    // Every expected event must have been consumed
    check_eq("ack_q_left",    32'(ack_q.size()), 32'd0);
    check_eq("wr_q_left",     32'(wr_q.size()), 32'd0);
    check_eq("rdptr_q_left",  32'(rdptr_q.size()), 32'd0);
    check_eq("rdbyte_q_left", 32'(rdbyte_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
